// File: rtl/mem_map_pkg.sv
// Shared memory-map constants for the data-memory responder: MMIO window
// base, register offsets inside the window and CONS_STATUS bit layout.
package mem_map_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

    localparam logic [15:0] CONS_DATA_OFF   = 16'h0;
    localparam logic [15:0] CONS_STATUS_OFF = 16'h4;
    localparam logic [15:0] CYCLE_OFF       = 16'h8;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_LEVEL_LSB = 8;

    // Assemble the CONS_STATUS read word from its individual fields.
    function automatic logic [31:0] status_word(input logic [7:0] level,
                                                input logic       ovf,
                                                input logic       full,
                                                input logic       empty);
        logic [31:0] w;
        w                      = '0;
        w[ST_LEVEL_LSB +: 8]   = level;
        w[ST_OVF]              = ovf;
        w[ST_FULL]             = full;
        w[ST_EMPTY]            = empty;
        return w;
    endfunction

endpackage

// File: rtl/data_mem_responder_sync_fifo.sv
// sync_fifo: circular-buffer FIFO with registered storage and an extra
// pointer bit so full and empty are distinguishable. The head word is
// presented on dout and reads as zero while the FIFO is empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign level = wptr_q - rptr_q;
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);
    assign dout  = empty ? '0 : mem_q[rptr_q[AW-1:0]];

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // accepted when it coincides with a pop.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Next-state pointer arithmetic.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop_ok)  rptr_d = rptr_q + 1'b1;
    end

    // Pointer registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage write; contents are not reset.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) mem_q[wptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: data-bus slave for the single-cycle core. Decodes a
// word-addressed RAM below MMIO_BASE and an MMIO window above it holding
// the console TX FIFO (CONS_DATA / CONS_STATUS) and a cycle counter
// (CYCLE). Reads are combinational; all state changes on posedge clk.
// Build option: define CYCLE_COUNTER_EN to include the cycle counter;
// without it CYCLE reads return 0 and CYCLE writes are ignored.
module data_mem_responder
    import mem_map_pkg::*;
#(
    parameter int          DATA_MEM_WORDS = 1024,
    parameter int          FIFO_DEPTH     = 8,
    parameter logic [31:0] MMIO_BASE      = MMIO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_writedata,
    output logic [31:0] mem_readdata,
    output logic        cons_valid,
    output logic [7:0]  cons_data,
    input  logic        cons_ready
);
    localparam int IW = $clog2(DATA_MEM_WORDS);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   ram_q [DATA_MEM_WORDS];
    logic          is_mmio;
    logic [15:0]   mmio_off;
    logic [IW-1:0] ram_idx;

    logic          wr_cons;
    logic          wr_status;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;
    logic          ovf_event;
    logic          overflow_q, overflow_d;
    logic [31:0]   status;
    logic [31:0]   cycle_value;

    assign is_mmio  = (mem_addr >= MMIO_BASE);
    assign mmio_off = mem_addr[15:0];
    assign ram_idx  = mem_addr[2 +: IW];

    assign wr_cons   = memwrite && !reset && is_mmio && (mmio_off == CONS_DATA_OFF);
    assign wr_status = memwrite && !reset && is_mmio && (mmio_off == CONS_STATUS_OFF);

    assign cons_valid = !fifo_empty;
    assign fifo_pop   = cons_valid && cons_ready && !reset;
    assign fifo_push  = wr_cons;

    // A byte is dropped only when the FIFO is full and nothing leaves it
    // in the same cycle.
    assign ovf_event = wr_cons && fifo_full && !fifo_pop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_cons_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (mem_writedata[7:0]),
        .dout  (cons_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign status = status_word(8'(fifo_level), overflow_q, fifo_full, fifo_empty);

    // Sticky overflow: a new overflow event wins over a same-cycle clear.
    always_comb begin
        overflow_d = overflow_q;
        if (ovf_event)
            overflow_d = 1'b1;
        else if (wr_status && mem_writedata[ST_OVF])
            overflow_d = 1'b0;
    end

    // Overflow flag register.
    always_ff @(posedge clk) begin
        if (reset) overflow_q <= 1'b0;
        else       overflow_q <= overflow_d;
    end

`ifdef CYCLE_COUNTER_EN
    logic        wr_cycle;
    logic [31:0] cycle_q, cycle_d;

    assign wr_cycle    = memwrite && !reset && is_mmio && (mmio_off == CYCLE_OFF);
    assign cycle_value = cycle_q;

    // A software write replaces the increment for that cycle.
    always_comb begin
        cycle_d = cycle_q + 32'd1;
        if (wr_cycle) cycle_d = mem_writedata;
    end

    // Free-running cycle counter register.
    always_ff @(posedge clk) begin
        if (reset) cycle_q <= '0;
        else       cycle_q <= cycle_d;
    end
`else
    assign cycle_value = '0;
`endif

    // RAM store port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (memwrite && !reset && !is_mmio) ram_q[ram_idx] <= mem_writedata;
    end

    // Combinational load mux; returns the pre-store value on read+write.
    always_comb begin
        mem_readdata = '0;
        if (memread) begin
            if (!is_mmio) begin
                mem_readdata = ram_q[ram_idx];
            end else begin
                case (mmio_off)
                    CONS_STATUS_OFF: mem_readdata = status;
                    CYCLE_OFF:       mem_readdata = cycle_value;
                    default:         mem_readdata = '0;
                endcase
            end
        end
    end

endmodule
